// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter. TXDATA/STATUS/DIV window, byte FIFO, serializer FSM.
// Never back-pressures the core: a push to a full FIFO is dropped and sets a sticky overflow flag.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          FIFO_DEPTH  = 8,
  parameter int          DEFAULT_DIV = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [2:0]  memsize,
  input  logic [31:0] addr,
  input  logic [31:0] writedata,
  output logic        sel,
  output logic [31:0] readdata,
  output logic        tx
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [CW-1:0] count;
  logic          overflow;
  logic [15:0]   div;
  logic [15:0]   frame_div;
  logic [15:0]   bit_cnt;
  logic [7:0]    shreg;
  logic [2:0]    bit_idx;
  state_t        state;

  logic wr_en, wr_tx, wr_status, wr_div;
  logic fifo_empty, fifo_full, bit_end, pop, push;
  logic unused;

  assign sel       = (addr[31:4] == BASE_ADDR[31:4]);
  assign wr_en     = memwrite && sel && (addr[1:0] == 2'b00);
  assign wr_tx     = wr_en && (addr[3:2] == 2'd0);
  assign wr_status = wr_en && (addr[3:2] == 2'd1);
  assign wr_div    = wr_en && (addr[3:2] == 2'd2);

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CW'(FIFO_DEPTH));
  assign bit_end    = (bit_cnt == frame_div - 16'd1);
  // A pop frees a slot on the same edge, so a push into a full FIFO still lands then.
  assign pop  = !fifo_empty && ((state == IDLE) || ((state == STOP) && bit_end));
  assign push = wr_tx && (!fifo_full || pop);

  assign unused = ^{memsize, writedata[31:16]};

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= writedata[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      if (wr_tx && !push)
        overflow <= 1'b1;
      else if (wr_status && writedata[2])
        overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      div <= 16'(DEFAULT_DIV);
    else if (wr_div)
      div <= (writedata[15:0] == 16'd0) ? 16'd1 : writedata[15:0];
  end

  // frame_div is latched at pop so DIV writes only affect the next frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      tx        <= 1'b1;
      shreg     <= '0;
      frame_div <= 16'(DEFAULT_DIV);
      bit_cnt   <= '0;
      bit_idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            shreg     <= mem[rptr];
            frame_div <= div;
            bit_cnt   <= '0;
            bit_idx   <= '0;
            tx        <= 1'b0;
            state     <= START;
          end
        end
        START: begin
          if (bit_end) begin
            bit_cnt <= '0;
            tx      <= shreg[0];
            state   <= DATA;
          end else begin
            bit_cnt <= bit_cnt + 16'd1;
          end
        end
        DATA: begin
          if (bit_end) begin
            bit_cnt <= '0;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shreg   <= shreg >> 1;
              tx      <= shreg[1];
            end
          end else begin
            bit_cnt <= bit_cnt + 16'd1;
          end
        end
        STOP: begin
          if (bit_end) begin
            bit_cnt <= '0;
            if (pop) begin
              shreg     <= mem[rptr];
              frame_div <= div;
              bit_idx   <= '0;
              tx        <= 1'b0;
              state     <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            bit_cnt <= bit_cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    readdata = '0;
    if (sel && (addr[1:0] == 2'b00)) begin
      case (addr[3:2])
        2'd1: begin
          readdata[0]    = fifo_full;
          readdata[1]    = fifo_empty;
          readdata[2]    = overflow;
          readdata[3]    = (state != IDLE);
          readdata[12:8] = 5'(count);
        end
        2'd2:    readdata[15:0] = div;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: frame-level reference model checked every cycle, plus directed literal checks.
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int DEPTH = 8;
  localparam int DEF_DIV = 16;
  localparam logic [31:0] A_TX = BASE + 32'h0;
  localparam logic [31:0] A_ST = BASE + 32'h4;
  localparam logic [31:0] A_DV = BASE + 32'h8;

  logic        clk = 1'b0;
  logic        reset;
  logic        memwrite;
  logic [2:0]  memsize;
  logic [31:0] addr;
  logic [31:0] writedata;
  logic        sel;
  logic [31:0] readdata;
  logic        tx;

  mmio_uart_tx #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH), .DEFAULT_DIV(DEF_DIV)) dut (
    .clk(clk), .reset(reset), .memwrite(memwrite), .memsize(memsize),
    .addr(addr), .writedata(writedata), .sel(sel), .readdata(readdata), .tx(tx)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  logic chk_on = 1'b0;

  // Reference model: FIFO as a queue, the line as (byte, divider, cycles into frame).
  logic [7:0]  q[$];
  logic        ovf;
  logic [15:0] mdiv;
  int          mfd;
  int          mpos;
  logic        mbusy;
  logic [7:0]  mbyte;
  int          cyc = 0;
  int          c0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic exp_tx();
    int k;
    if (!mbusy) return 1'b1;
    k = mpos / mfd;
    if (k == 0) return 1'b0;
    if (k <= 8) return mbyte[k-1];
    return 1'b1;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [31:0] a);
    int n;
    n = q.size();
    if (a[31:4] != BASE[31:4] || a[1:0] != 2'b00) return 32'h0;
    case (a[3:0])
      4'h4: return 32'(n * 256 + (mbusy ? 8 : 0) + (ovf ? 4 : 0) +
                       (n == 0 ? 2 : 0) + (n == DEPTH ? 1 : 0));
      4'h8: return {16'h0, mdiv};
      default: return 32'h0;
    endcase
  endfunction

  initial begin : model
    logic wsel, fend, pop;
    logic [7:0] popped;
    q.delete(); ovf = 1'b0; mdiv = 16'(DEF_DIV); mfd = 1; mpos = 0; mbusy = 1'b0; mbyte = 8'h0;
    forever begin
      @(posedge clk);
      cyc++;
      if (reset) begin
        q.delete(); ovf = 1'b0; mdiv = 16'(DEF_DIV); mbusy = 1'b0; mpos = 0;
      end else begin
        wsel = memwrite && (addr[31:4] == BASE[31:4]) && (addr[1:0] == 2'b00);
        fend = mbusy && (mpos == 10 * mfd - 1);
        pop  = (!mbusy || fend) && (q.size() > 0);
        popped = 8'h0;
        if (pop) popped = q.pop_front();
        if (wsel && addr[3:0] == 4'h0) begin
          if (q.size() < DEPTH) q.push_back(writedata[7:0]);
          else ovf = 1'b1;
        end
        if (wsel && addr[3:0] == 4'h4 && writedata[2]) ovf = 1'b0;
        if (pop) begin
          mbyte = popped; mfd = int'(mdiv); mbusy = 1'b1; mpos = 0;
        end else if (fend) begin
          mbusy = 1'b0;
        end else if (mbusy) begin
          mpos++;
        end
        if (wsel && addr[3:0] == 4'h8)
          mdiv = (writedata[15:0] == 16'h0) ? 16'h1 : writedata[15:0];
      end
    end
  end

  initial begin : compare
    forever begin
      @(negedge clk);
      if (chk_on) begin
        check("tx", {31'h0, tx}, {31'h0, exp_tx()});
        check("sel", {31'h0, sel}, {31'h0, addr[31:4] == BASE[31:4]});
        check("readdata", readdata, exp_rd(addr));
      end
    end
  end

  task automatic set_in(input logic rst, input logic mw, input logic [31:0] a, input logic [31:0] wd);
    @(posedge clk);
    #1;
    reset = rst; memwrite = mw; addr = a; writedata = wd; memsize = 3'($urandom);
  endtask

  // Follows the line until busy drops; exp_len is edges from the first write to idle.
  task automatic watch(input int exp_len, input logic chk_pat, input logic [9:0] pat, input int fd);
    int d;
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      d = cyc - c0;
      if (chk_pat && d >= 1 && d <= 10 * fd) check("tx_pattern", {31'h0, tx}, {31'h0, pat[(d-1)/fd]});
      if (readdata[3]) seen = 1'b1;
      else if (seen) begin
        check("frame_length", 32'(d), 32'(exp_len));
        return;
      end
    end
    vectors++;
    miscompares++;
    $display("FAIL watch_timeout: busy never cleared, required length %0d", exp_len);
  endtask

  initial begin : stim
    int r;
    logic [31:0] ra, rw;
    reset = 1'b1; memwrite = 1'b0; memsize = 3'h0; addr = 32'h0; writedata = 32'h0;
    set_in(1, 0, A_ST, 0);
    chk_on = 1'b1;
    set_in(0, 0, A_ST, 0);
    @(negedge clk);
    check("reset_tx", {31'h0, tx}, 32'h1);
    check("reset_status", readdata, 32'h0000_0002);
    set_in(0, 0, A_DV, 0);
    @(negedge clk);
    check("reset_div", readdata, 32'h0000_0010);

    // Single 0xA5 frame at DIV=4
    set_in(0, 1, A_DV, 4);
    set_in(0, 1, A_TX, 32'h0000_00A5);
    c0 = cyc + 1;
    set_in(0, 0, A_ST, 0);
    watch(41, 1'b1, {1'b1, 8'hA5, 1'b0}, 4);
    check("a5_idle_status", readdata, 32'h0000_0002);

    // Ten back-to-back pushes at DIV=16; the tenth is dropped
    set_in(0, 1, A_DV, 16);
    for (int i = 1; i <= 10; i++) begin
      set_in(0, 1, A_TX, 32'(i));
      if (i == 1) c0 = cyc + 1;
    end
    set_in(0, 0, A_ST, 0);
    @(negedge clk);
    check("full_status", readdata, 32'h0000_080D);
    set_in(0, 1, A_ST, 32'h4);
    set_in(0, 0, A_ST, 0);
    @(negedge clk);
    check("ovf_clear_status", readdata, 32'h0000_0809);
    watch(1441, 1'b0, 10'h0, 16);

    set_in(0, 1, A_DV, 0);
    set_in(0, 0, A_DV, 0);
    @(negedge clk);
    check("div_zero_is_one", readdata, 32'h0000_0001);

    // DIV change mid-frame applies to the following frame only
    set_in(0, 1, A_DV, 8);
    set_in(0, 1, A_TX, 32'h3C);
    c0 = cyc + 1;
    set_in(0, 1, A_TX, 32'hC3);
    for (int i = 0; i < 20; i++) set_in(0, 0, A_ST, 0);
    set_in(0, 1, A_DV, 3);
    set_in(0, 0, A_DV, 0);
    @(negedge clk);
    check("div_mid_frame", readdata, 32'h0000_0003);
    set_in(0, 0, A_ST, 0);
    watch(111, 1'b0, 10'h0, 8);

    // Decode boundaries
    set_in(0, 1, BASE + 32'h10, 32'h55);
    @(negedge clk);
    check("win_plus_10_sel", {31'h0, sel}, 32'h0);
    check("win_plus_10_rd", readdata, 32'h0);
    set_in(0, 1, 32'h1234_0000, 32'h55);
    @(negedge clk);
    check("outside_sel", {31'h0, sel}, 32'h0);
    set_in(0, 1, BASE + 32'h1, 32'h66);
    set_in(0, 0, A_TX, 32'h77);
    set_in(0, 0, BASE + 32'h9, 0);
    @(negedge clk);
    check("misaligned_rd", readdata, 32'h0);
    set_in(0, 0, A_ST, 0);
    @(negedge clk);
    check("no_push_status", readdata, 32'h0000_0002);

    // Reset during DATA bit 3 with bytes still queued
    set_in(0, 1, A_DV, 5);
    set_in(0, 1, A_TX, 32'hFF);
    c0 = cyc + 1;
    set_in(0, 1, A_TX, 32'h11);
    set_in(0, 1, A_TX, 32'h22);
    for (int i = 0; i < 100 && cyc < c0 + 22; i++) set_in(0, 0, A_ST, 0);
    set_in(1, 0, A_ST, 0);
    set_in(0, 0, A_ST, 0);
    @(negedge clk);
    check("midreset_tx", {31'h0, tx}, 32'h1);
    check("midreset_status", readdata, 32'h0000_0002);
    set_in(0, 0, A_DV, 0);
    @(negedge clk);
    check("midreset_div", readdata, 32'h0000_0010);

    // Randomized traffic against the model
    set_in(0, 1, A_DV, 2);
    for (int n = 0; n < 15000; n++) begin
      r  = $urandom_range(0, 99);
      rw = $urandom;
      if (r < 15) begin
        set_in(0, 1, A_TX, rw);
      end else if (r < 20) begin
        set_in(0, 1, A_ST, rw);
      end else if (r < 24) begin
        rw[15:0] = 16'($urandom_range(0, 4));
        set_in(0, 1, A_DV, rw);
      end else if (r < 30) begin
        ra = $urandom;
        if (ra[31:4] == BASE[31:4]) ra[31] = ~ra[31];
        set_in(0, 1, ra, rw);
      end else if (r < 35) begin
        ra = BASE + 32'(4 * $urandom_range(0, 3)) + 32'($urandom_range(1, 3));
        set_in(0, 1, ra, rw);
      end else begin
        ra = BASE + 32'($urandom_range(0, 15));
        set_in($urandom_range(0, 2999) == 0, 0, ra, rw);
      end
    end
    set_in(0, 0, A_ST, 0);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
Memory-mapped UART transmitter on the single-cycle core's data bus, downstream of the core's store path. It decodes memwrite/address/writedata, buffers bytes in a FIFO and serialises them as 8N1 frames on tx. It returns combinational readdata for status and divider reads; the top-level data mux selects it when sel=1. The core never stalls, so the block never back-pressures: writes to a full FIFO are dropped and flagged.

Parameters:
BASE_ADDR, 32'h8000_0000, 16-byte aligned base of the register window; decode uses bits [31:4].
FIFO_DEPTH, 8, TX FIFO entries; power of two, 2..16.
DEFAULT_DIV, 16, reset value of the DIV register (clocks per bit).

Ports:
clk  input  1  core clock
reset  input  1  synchronous, active-high reset
memwrite  input  1  store strobe from core
memsize  input  3  access size (funct3 encoding); ignored, only the low byte/halfword is used
addr  input  32  byte address (core aluout)
writedata  input  32  store data
sel  output  1  combinational: addr[31:4]==BASE_ADDR[31:4]
readdata  output  32  combinational register read; 0 when sel=0
tx  output  1  serial line, idle high

Behaviour:
- One clock, all state on rising clk; reset is synchronous and active-high.
- Register map (offset = addr[3:0]); accesses with addr[1:0]!=0 are ignored on write and read as 0.
  - 0x0 TXDATA: write pushes writedata[7:0]; reads as 0.
  - 0x4 STATUS, read: bit0 full, bit1 empty, bit2 overflow (sticky), bit3 busy (state!=IDLE), bits[12:8] count, others 0. Write with writedata[2]=1 clears overflow; other bits ignored.
  - 0x8 DIV: RW, 16 bits in [15:0], upper bits read 0. A written value of 0 is stored as 1.
  - 0xC: reserved; reads 0, writes ignored.
- A write takes effect only when memwrite && sel.
- Reset values: tx=1, FIFO empty (count 0), overflow 0, DIV=DEFAULT_DIV, state IDLE, bit counters 0. sel and readdata are combinational only.
- FIFO push on a TXDATA write:
  - Accepted if count<FIFO_DEPTH, or if a pop occurs on the same edge.
  - Otherwise the byte is dropped and overflow is set.
  - Count updates at the write edge. Pointers wrap modulo FIFO_DEPTH.
- Serializer FSM, states IDLE, START, DATA, STOP:
  - IDLE: if FIFO is non-empty, pop into the shift register, latch DIV into frame_div, go to START. The first pop happens at the edge after the write edge, so tx falls 1 cycle after the write edge.
  - START: tx=0 for frame_div cycles, then DATA.
  - DATA: 8 bits LSB first, each held frame_div cycles; a 3-bit index counts 0..7, then STOP.
  - STOP: tx=1 for frame_div cycles. At the end, if the FIFO is non-empty, pop and go straight to START (back-to-back frames, no idle gap); else go to IDLE.
  - Frame length is exactly 10*frame_div cycles.
- DIV writes during a frame do not affect the current frame; they apply at the next pop.
- Reset mid-frame: at the reset edge tx=1, the FIFO is discarded and the partial frame is abandoned.
- Simultaneous STATUS overflow-clear and a dropped TXDATA write cannot occur (single bus). A drop and a clear in different cycles resolve in order.

Test Plan:
- DIV=4, write 0xA5 to TXDATA: tx=0 during cycles 1..4 after the write edge, then bits 1,0,1,0,0,1,0,1 (4 cycles each), stop 1 for 4 cycles; busy=1 for 40 cycles; empty=1 afterward.
- DIV=16, 10 back-to-back TXDATA writes (0x01..0x0A): 0x01 popped at once, 0x02..0x09 fill the FIFO, 0x0A dropped. STATUS reads full=1, count=8, overflow=1. tx emits 0x01..0x09 back-to-back: 9 frames in 160 cycles each, no gaps.
- Write STATUS with writedata=0x4: overflow reads 0; count and full are unchanged.
- Write DIV=0 -> reads 1; write DIV=3 mid-frame (from 8): the current frame keeps 8-cycle bits, the next frame uses 3-cycle bits.
- Store to BASE_ADDR+0x10 and to a non-window address with memwrite=1: sel=0, readdata=0, no FIFO change; memwrite=0 at TXDATA: no push.
- Assert reset during DATA bit 3: next cycle tx=1, STATUS reads empty=1, count=0, busy=0, DIV=DEFAULT_DIV.
